// File: rtl/spi_regfile_rw.sv
// SPI mode-0 target holding the five 8-bit PWM control registers (16-bit frames: R/W, addr[6:0], data).
// Define SPI_READBACK_EN to build the read shadow and CIPO readback path; otherwise cipo/cipo_oe are tied low.
module spi_regfile_rw #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  localparam int unsigned N_REGS = 5;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FILL_W = 3;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_q, ncs_q;
  logic                   sclk_rise, ncs_rise;
  logic [FILL_W-1:0]      fill_cnt;
  logic                   fill_done, armed;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              rw_q, rw_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt, hdr_addr;
  logic              addr_ok;
  logic              wr_en, wr_en_nxt;
  logic              err_nxt;
  logic [DATA_W-1:0] regs [N_REGS];

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] shadow, shadow_nxt, rd_val;
  logic              rd_act, rd_act_nxt;
  logic              cipo_nxt;
`endif

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_rise  = ncs_s & ~ncs_q;
  assign fill_done = (fill_cnt == FILL_W'(SYNC_STAGES));
  assign hdr_addr  = {sh[5:0], copi_s};
  assign addr_ok   = (addr_q <= ADDR_W'(MAX_ADDR));

  // Synchronisers and edge history; armed only once a genuine ncs-high has been seen after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      fill_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_q    <= sclk_s;
      ncs_q     <= ncs_s;
      if (!fill_done) fill_cnt <= fill_cnt + FILL_W'(1);
      if (fill_done && ncs_s) armed <= 1'b1;
    end
  end

`ifdef SPI_READBACK_EN
  assign sclk_fall = ~sclk_s & sclk_q;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i) && i <= MAX_ADDR) rd_val = regs[i];
    end
  end
`endif

  // Next-state and datapath; an ncs rise outranks any sclk edge in the same cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    rw_nxt    = rw_q;
    addr_nxt  = addr_q;
    wr_en_nxt = 1'b0;
    err_nxt   = 1'b0;
`ifdef SPI_READBACK_EN
    shadow_nxt = shadow;
    rd_act_nxt = rd_act;
`endif
    case (state)
      S_IDLE: begin
`ifdef SPI_READBACK_EN
        rd_act_nxt = 1'b0;
`endif
        if (armed && !ncs_s) begin
          state_nxt = S_ADDR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (ncs_rise) begin
          state_nxt = S_IDLE;
          if (state == S_DONE) wr_en_nxt = rw_q & addr_ok;
          else                 err_nxt   = 1'b1;
`ifdef SPI_READBACK_EN
          rd_act_nxt = 1'b0;
`endif
        end else if (sclk_rise) begin
          if (state == S_ADDR || state == S_DATA) begin
            sh_nxt  = {sh[6:0], copi_s};
            cnt_nxt = cnt + CNT_W'(1);
          end
          if (state == S_ADDR && cnt == CNT_W'(7)) begin
            state_nxt = S_DATA;
            rw_nxt    = sh[6];
            addr_nxt  = hdr_addr;
`ifdef SPI_READBACK_EN
            if (!sh[6]) begin
              shadow_nxt = rd_val;
              rd_act_nxt = 1'b1;
            end
`endif
          end
          if (state == S_DATA && cnt == CNT_W'(15)) state_nxt = S_DONE;
          if (state == S_DONE) state_nxt = S_ERR;
        end
`ifdef SPI_READBACK_EN
        // The fall right after the last address bit keeps bit7 up for the controller's first data sample
        else if (sclk_fall && rd_act && state == S_DATA && cnt > CNT_W'(8)) begin
          shadow_nxt = {shadow[6:0], 1'b0};
        end
`endif
      end
    endcase
`ifdef SPI_READBACK_EN
    cipo_nxt = (rd_act_nxt && !ncs_s) ? shadow_nxt[7] : 1'b0;
`endif
  end

  // sh and addr_q are frozen in IDLE, so the write one cycle after commit uses them directly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sh        <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sh        <= sh_nxt;
      rw_q      <= rw_nxt;
      addr_q    <= addr_nxt;
      wr_en     <= wr_en_nxt;
      frame_err <= err_nxt;
      if (wr_en) begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) regs[i] <= sh;
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= '0;
      rd_act  <= 1'b0;
      cipo    <= 1'b0;
      cipo_oe <= 1'b0;
    end else begin
      shadow  <= shadow_nxt;
      rd_act  <= rd_act_nxt;
      cipo    <= cipo_nxt;
      cipo_oe <= ~ncs_s;
    end
  end
`else
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Bench for spi_regfile_rw: directed vector table, randomized frames against a register-array model,
// plus hand sequences for commit latency and reset in mid-frame.
module tb_spi_regfile_rw;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MAX_ADDR    = 4;
  localparam int          HALF        = 5;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, sclk, copi, ncs;
  logic cipo, cipo_oe, frame_err;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  always #5 clk = ~clk;

  spi_regfile_rw #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .frame_err(frame_err)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int err_total = 0;
  logic [7:0] model [5];

  always @(negedge clk) if (frame_err === 1'b1) err_total++;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic [39:0] exp_regs;
    logic [7:0]  exp_rd;
    int          exp_err;
  } vec_t;
  vec_t tab [9];

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [7:0] model_read(input logic [6:0] a);
    logic [2:0] idx;
    idx = a[2:0];
    if (a <= 7'(MAX_ADDR)) return model[idx];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Clock out bits [from,to) of a frame with ncs already low; samples cipo just before each data-bit rise
  task automatic shift_bits(input logic [15:0] word, input int from, input int to, inout logic [7:0] rd);
    for (int i = from; i < to; i++) begin
      copi = (i < 16) ? word[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i < 16) rd[15-i] = cipo;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] word, input int nbits,
                           output logic [7:0] rd, output logic oe, output int errs);
    int snap;
    snap = err_total;
    rd = 8'h00;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    oe = cipo_oe;
    shift_bits(word, 0, nbits, rd);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    copi = 1'b0;
    repeat (15) @(negedge clk);
    errs = err_total - snap;
  endtask

  logic [7:0]  rd;
  logic        oe;
  int          errs;
  int          first;
  logic [15:0] w;
  int          nb;
  logic [7:0]  exp_rd;
  int          nb_opts [8];

  initial begin
    nb_opts = '{8, 12, 15, 16, 16, 16, 17, 16};
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_regs", dut_regs(), 40'h0);
    check("reset_oe", 40'(cipo_oe), 40'h0);
    check("reset_cipo", 40'(cipo), 40'h0);
    check("reset_err", 40'(err_total), 40'h0);

    // Commit latency from raw ncs rise to pwm_duty_cycle update
    rd = 8'h00;
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(16'h8480, 0, 16, rd);
    repeat (HALF) @(negedge clk);
    first = 0;
    ncs = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (first == 0 && pwm_duty_cycle == 8'h80) first = k;
    end
    repeat (10) @(negedge clk);
    check("commit_latency", 40'(first), 40'(SYNC_STAGES + 2));
    check("lat_regs", dut_regs(), 40'h80_00_00_00_00);
    check("lat_err", 40'(err_total), 40'h0);

    tab[0] = '{16'h80FF, 16, 40'h80_00_00_00_FF, 8'h00, 0};
    tab[1] = '{16'h81A5, 16, 40'h80_00_00_A5_FF, 8'h00, 0};
    tab[2] = '{16'h823C, 16, 40'h80_00_3C_A5_FF, 8'h00, 0};
    tab[3] = '{16'h83C3, 16, 40'h80_C3_3C_A5_FF, 8'h00, 0};
    tab[4] = '{16'h8577, 16, 40'h80_C3_3C_A5_FF, 8'h00, 0};
    tab[5] = '{16'h8411, 12, 40'h80_C3_3C_A5_FF, 8'h00, 1};
    tab[6] = '{16'h8411, 17, 40'h80_C3_3C_A5_FF, 8'h00, 1};
    tab[7] = '{16'h0100, 16, 40'h80_C3_3C_A5_FF, RB ? 8'hA5 : 8'h00, 0};
    tab[8] = '{16'h1000, 16, 40'h80_C3_3C_A5_FF, 8'h00, 0};

    for (int t = 0; t < 9; t++) begin
      run_frame(tab[t].word, tab[t].nbits, rd, oe, errs);
      check($sformatf("tab%0d_regs", t), dut_regs(), tab[t].exp_regs);
      check($sformatf("tab%0d_err", t), 40'(errs), 40'(tab[t].exp_err));
      check($sformatf("tab%0d_cipo", t), 40'(rd), 40'(tab[t].exp_rd));
      check($sformatf("tab%0d_oe", t), 40'(oe), 40'(RB));
    end

    model[0] = 8'hFF; model[1] = 8'hA5; model[2] = 8'h3C; model[3] = 8'hC3; model[4] = 8'h80;

    // Random frames: only complete 16-bit writes to implemented addresses change anything
    for (int r = 0; r < 40; r++) begin
      w[15]   = 1'($urandom_range(0, 1));
      w[14:8] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      w[7:0]  = 8'($urandom_range(0, 255));
      nb = nb_opts[$urandom_range(0, 7)];
      exp_rd = (RB && !w[15]) ? model_read(w[14:8]) : 8'h00;
      run_frame(w, nb, rd, oe, errs);
      if (nb == 16 && w[15] && w[14:8] <= 7'(MAX_ADDR)) model[w[10:8]] = w[7:0];
      check($sformatf("rnd%0d_regs w=%h n=%0d", r, w, nb), dut_regs(), model_regs());
      check($sformatf("rnd%0d_err w=%h n=%0d", r, w, nb), 40'(errs), 40'((nb != 16) ? 1 : 0));
      if (nb >= 16)
        check($sformatf("rnd%0d_cipo w=%h", r, w), 40'(rd), 40'(exp_rd));
    end

    // Reset pulse after bit 10 of 0x8033; rest of that frame must be ignored
    ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(16'h8033, 0, 10, rd);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_regs_now", dut_regs(), 40'h0);
    first = err_total;
    shift_bits(16'h8033, 10, 16, rd);
    repeat (HALF) @(negedge clk);
    ncs = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_regs", dut_regs(), 40'h0);
    check("midrst_err", 40'(err_total - first), 40'h0);
    run_frame(16'h8033, 16, rd, oe, errs);
    check("after_rst_regs", dut_regs(), 40'h00_00_00_00_33);
    check("after_rst_err", 40'(errs), 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
